debounce_fsm: RTL and testbench

- Filters a raw, bouncing, asynchronous input (push-button or slide switch on the board) into a clean registered level.
- Sits directly upstream of the positive-edge detector. Its d_out feeds the edge detector's d_in, so one physical press yields exactly one single-cycle pulse into the UART transmit/load logic.
- Uses a two-stage synchronizer, a stability counter and a 4-state FSM.

---
 rtl/uart_pkg.sv | 22 ++
 rtl/sync_2ff.sv | 22 ++
 rtl/debounce_fsm.sv | 111 +++++++++++
 tb/tb_debounce_fsm.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the board-input conditioning blocks (debounce, edge detect, UART load).
package uart_pkg;

  // Stability window that is reused by every board-input block: 10 ms at 100 MHz.
  localparam int unsigned DEFAULT_STABLE_CNT = 1000000;
  localparam int unsigned DEFAULT_CNT_W      = 20;

  // Debounce FSM state encoding. Neighbouring states differ in exactly one bit.
  localparam int unsigned STATE_W = 2;
  typedef logic [STATE_W-1:0] state_t;

  localparam logic [1:0] IDLE_LOW  = 2'b00;
  localparam logic [1:0] WAIT_HIGH = 2'b01;
  localparam logic [1:0] IDLE_HIGH = 2'b11;
  localparam logic [1:0] WAIT_LOW  = 2'b10;

  // True while a candidate transition is being qualified.
  function automatic logic is_wait_state(input state_t st);
    return (st == WAIT_HIGH) || (st == WAIT_LOW);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous bit, synchronous active-low reset.
module sync_2ff (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  // Shift the raw bit through two flops; both clear on reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/debounce_fsm.sv
// Debounces a raw pad input into a clean registered level for the downstream edge detector.
// Optional macro DEBOUNCE_SYNC_EN inserts a 2-flop synchronizer on d_in (2 extra cycles of latency);
// without it the FSM samples d_in directly, for inputs that are already synchronous.
module debounce_fsm
  import uart_pkg::*;
#(
  parameter int unsigned STABLE_CNT = DEFAULT_STABLE_CNT,
  parameter int unsigned CNT_W      = DEFAULT_CNT_W
) (
  input  logic clk,
  input  logic reset,
  input  logic d_in,
  output logic d_out,
  output logic busy
);

  // Count value reached on the last stable edge of a qualification window.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CNT - 1);

  logic             s;
  state_t           state;
  state_t           state_n;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_n;
  logic             d_out_n;
  logic             busy_n;

`ifdef DEBOUNCE_SYNC_EN
  // Bring the asynchronous pad into the clk domain before the FSM looks at it.
  sync_2ff u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (d_in),
    .q     (s)
  );
`else
  // Input is already synchronous; sample it directly.
  assign s = d_in;
`endif

  // State, counter and output registers; reset aborts any qualification in progress.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE_LOW;
      cnt   <= '0;
      d_out <= 1'b0;
      busy  <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      d_out <= d_out_n;
      busy  <= busy_n;
    end
  end

  // Next-state logic: a bounce always beats the terminal-count compare.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    d_out_n = d_out;
    case (state)
      IDLE_LOW: begin
        if (s) begin
          state_n = WAIT_HIGH;
          cnt_n   = '0;
        end
      end
      WAIT_HIGH: begin
        if (!s) begin
          state_n = IDLE_LOW;
          cnt_n   = '0;
        end else if (cnt == CNT_LAST) begin
          state_n = IDLE_HIGH;
          cnt_n   = '0;
          d_out_n = 1'b1;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      IDLE_HIGH: begin
        if (!s) begin
          state_n = WAIT_LOW;
          cnt_n   = '0;
        end
      end
      WAIT_LOW: begin
        if (s) begin
          state_n = IDLE_HIGH;
          cnt_n   = '0;
        end else if (cnt == CNT_LAST) begin
          state_n = IDLE_LOW;
          cnt_n   = '0;
          d_out_n = 1'b0;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      default: begin
        state_n = IDLE_LOW;
        cnt_n   = '0;
        d_out_n = 1'b0;
      end
    endcase
  end

  // busy is registered from the decoded next state.
  always_comb begin
    busy_n = is_wait_state(state_n);
  end

endmodule

// File: tb/tb_debounce_fsm.sv
// Self-checking bench for debounce_fsm: two instances (STABLE_CNT=4 and STABLE_CNT=1) share one stimulus.
// Reference model: a sampled-input delay line plus a "consecutive samples differing from the accepted
// level" run length; a level is accepted once the run reaches STABLE_CNT+1.
module tb_debounce_fsm;

  localparam int unsigned N_A = 4;
  localparam int unsigned W_A = 4;
  localparam int unsigned N_B = 1;
  localparam int unsigned W_B = 2;
`ifdef DEBOUNCE_SYNC_EN
  localparam int unsigned SYNC_LAT = 2;
`else
  localparam int unsigned SYNC_LAT = 0;
`endif

  logic clk   = 1'b0;
  logic reset = 1'b0;
  logic d_in  = 1'b0;
  logic d_out_a, busy_a, d_out_b, busy_b;

  always #5 clk = ~clk;

  debounce_fsm #(.STABLE_CNT(N_A), .CNT_W(W_A)) dut_a (
    .clk(clk), .reset(reset), .d_in(d_in), .d_out(d_out_a), .busy(busy_a)
  );

  debounce_fsm #(.STABLE_CNT(N_B), .CNT_W(W_B)) dut_b (
    .clk(clk), .reset(reset), .d_in(d_in), .d_out(d_out_b), .busy(busy_b)
  );

  int checks = 0;
  int errors = 0;

  // Model state
  logic pipe [0:1];
  logic lvl  [0:1];
  int   run  [0:1];
  int   lim  [0:1];
  int   edge_no;
  // Pulses a downstream rising-edge detector would emit on each DUT output
  int   pulses_a, pulses_b;
  logic prev_a, prev_b;

  task automatic check_val(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic model_clear();
    pipe[0] = 1'b0; pipe[1] = 1'b0;
    for (int k = 0; k < 2; k++) begin
      lvl[k] = 1'b0;
      run[k] = 0;
    end
  endtask

  // One clock: drive inputs at negedge, update model at posedge, compare shortly after.
  task automatic step(input logic rst_v, input logic d_v);
    logic s;
    @(negedge clk);
    reset = rst_v;
    d_in  = d_v;
    @(posedge clk);
    if (!rst_v) begin
      model_clear();
    end else begin
      s = (SYNC_LAT == 2) ? pipe[1] : d_v;
      pipe[1] = pipe[0];
      pipe[0] = d_v;
      for (int k = 0; k < 2; k++) begin
        if (s != lvl[k]) begin
          run[k]++;
          if (run[k] == lim[k] + 1) begin
            lvl[k] = s;
            run[k] = 0;
          end
        end else begin
          run[k] = 0;
        end
      end
    end
    edge_no++;
    #1;
    if (d_out_a && !prev_a) pulses_a++;
    if (d_out_b && !prev_b) pulses_b++;
    prev_a = d_out_a;
    prev_b = d_out_b;
    check_val("a_d_out", int'(d_out_a), int'(lvl[0]));
    check_val("a_busy",  int'(busy_a),  int'(run[0] != 0));
    check_val("b_d_out", int'(d_out_b), int'(lvl[1]));
    check_val("b_busy",  int'(busy_b),  int'(run[1] != 0));
  endtask

  task automatic hold(input logic d_v, input int n);
    for (int i = 0; i < n; i++) step(1'b1, d_v);
  endtask

  initial begin
    int rise_edge;
    int base_a, base_b;
    logic pat [0:5];

    lim[0] = N_A;
    lim[1] = N_B;
    model_clear();
    edge_no = 0;
    pulses_a = 0; pulses_b = 0;
    prev_a = 1'b0; prev_b = 1'b0;

    // Reset held with d_in high: outputs must stay cleared.
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b1);
      check_val("rst_d_out", int'(d_out_a), 0);
      check_val("rst_busy",  int'(busy_a), 0);
    end

    // Release with d_in still high; measure the acceptance edge.
    edge_no = 0;
    rise_edge = -1;
    for (int i = 0; i < 20 && rise_edge < 0; i++) begin
      step(1'b1, 1'b1);
      if (d_out_a) rise_edge = edge_no;
    end
    check_val("rst_release_rise_edge", rise_edge, int'(1 + SYNC_LAT + N_A));

    // Release path: fall after a held low, then a bounce back high inside WAIT_LOW.
    hold(1'b1, 6);
    hold(1'b0, 10 + SYNC_LAT);
    check_val("release_falls", int'(d_out_a), 0);
    hold(1'b1, 12);
    check_val("rehigh", int'(d_out_a), 1);
    hold(1'b0, 3);
    hold(1'b1, 8);
    check_val("wait_low_bounce_holds", int'(d_out_a), 1);

    // Clean press from a settled low: exactly one detector pulse per instance.
    hold(1'b0, 12);
    base_a = pulses_a;
    base_b = pulses_b;
    hold(1'b1, 20);
    check_val("press_pulses_a", pulses_a - base_a, 1);
    check_val("press_pulses_b", pulses_b - base_b, 1);

    // Bounce rejection on the 4-count instance.
    hold(1'b0, 12);
    pat[0] = 1'b1; pat[1] = 1'b1; pat[2] = 1'b0;
    pat[3] = 1'b1; pat[4] = 1'b1; pat[5] = 1'b0;
    base_a = pulses_a;
    for (int i = 0; i < 6; i++) step(1'b1, pat[i]);
    hold(1'b0, 10);
    check_val("bounce_d_out", int'(d_out_a), 0);
    check_val("bounce_busy",  int'(busy_a), 0);
    check_val("bounce_pulses", pulses_a - base_a, 0);

    // Terminal-count race: exactly STABLE_CNT high samples, then low.
    hold(1'b1, N_A);
    hold(1'b0, 8);
    check_val("term_race_d_out", int'(d_out_a), 0);
    check_val("term_race_busy",  int'(busy_a), 0);

    // Reset in the middle of a qualification (cnt==2 on the 4-count instance).
    hold(1'b1, SYNC_LAT + 3);
    check_val("midq_busy_before", int'(busy_a), 1);
    step(1'b0, 1'b1);
    check_val("midq_d_out", int'(d_out_a), 0);
    check_val("midq_busy",  int'(busy_a), 0);
    edge_no = 0;
    rise_edge = -1;
    for (int i = 0; i < 20 && rise_edge < 0; i++) begin
      step(1'b1, 1'b1);
      if (d_out_a) rise_edge = edge_no;
    end
    check_val("midq_rise_edge", rise_edge, int'(1 + SYNC_LAT + N_A));

    // Randomized bouncing segments with occasional resets.
    for (int seg = 0; seg < 80; seg++) begin
      logic v;
      int   len;
      v   = 1'($urandom_range(0, 1));
      len = int'($urandom_range(1, 9));
      for (int i = 0; i < len; i++) begin
        if ($urandom_range(0, 59) == 0) step(1'b0, v);
        else step(1'b1, v);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
